chan_mux_rr: RTL

//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes.

---
 rtl/chan_mux_rr_if.sv | 20 ++
 rtl/chan_mux_rr.sv | 54 +++++
 2 files changed

// File: rtl/chan_mux_rr_if.sv
// chan_mux_rr_if: producer-side channels plus the single downstream output of chan_mux_rr.
interface chan_mux_rr_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8
);
    localparam int SW = $clog2(N_CH);
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    in_valid;
    logic [N_CH-1:0]    in_ready;
    logic               mode;
    logic [SW-1:0]      sel;
    logic [DW-1:0]      out_data;
    logic [SW-1:0]      out_ch;
    logic               out_valid;
    logic               out_ready;
    modport master (output in_data, in_valid, mode, sel, out_ready,
                    input  in_ready, out_data, out_ch, out_valid);
    modport slave  (input  in_data, in_valid, mode, sel, out_ready,
                    output in_ready, out_data, out_ch, out_valid);
endinterface

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel registered mux, fixed-select or round-robin, valid/ready on both sides.
module chan_mux_rr #(
    parameter int N_CH = 4,
    parameter int DW   = 8
) (
    input logic         clk,
    input logic         rst_n,
    chan_mux_rr_if.slave bus
);
    localparam int SW = $clog2(N_CH);
    localparam int NP = 1 << SW;
    logic          can_load, gnt_v, xfer;
    logic [SW-1:0] gnt, idx, ptr;
    logic [NP-1:0] vpad, rpad;
    always_comb begin
        can_load = !bus.out_valid || bus.out_ready;
        vpad = '0;
        vpad[N_CH-1:0] = bus.in_valid;
        gnt = bus.sel;
        gnt_v = 1'b0;
        idx = '0;
        if (!bus.mode)
            gnt_v = (int'(bus.sel) < N_CH) && vpad[bus.sel];
        else
            // scan downwards so the lowest offset from ptr wins
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = SW'((int'(ptr) + k) % N_CH);
                if (vpad[idx]) begin
                    gnt = idx;
                    gnt_v = 1'b1;
                end
            end
        rpad = '0;
        rpad[gnt] = can_load && (bus.mode ? gnt_v : (int'(bus.sel) < N_CH));
        bus.in_ready = rst_n ? rpad[N_CH-1:0] : '0;
        xfer = gnt_v && can_load;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.out_data  <= bus.in_data[int'(gnt)*DW +: DW];
            bus.out_ch    <= gnt;
            bus.out_valid <= 1'b1;
            if (bus.mode)
                ptr <= (int'(gnt) == N_CH - 1) ? '0 : gnt + 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
